rr_decode_arbiter: RTL

//   Round-robin scheduler that shares one 3-to-8 decoder-driven resource among
//   8 requesters. Produces the registered 3-bit select and enable that feed the

---
 rtl/rr_decode_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/rr_decode_arbiter.sv
// Round-robin owner selection for one 3-to-8 decoded resource shared by 8 requesters.
// Registered select/enable feed the decoder; grants are bounded in length and separated by one dead cycle.
module rr_decode_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int HCNT_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        req,
    input  logic              done,
    output logic [2:0]        gnt_idx,
    output logic              gnt_en,
    output logic [7:0]        gnt,
    output logic              busy,
    output logic              timeout
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(MAX_HOLD - 1);

    logic [1:0]        state_q,    state_d;
    logic [2:0]        ptr_q,      ptr_d;
    logic [2:0]        gnt_idx_q,  gnt_idx_d;
    logic              gnt_en_q,   gnt_en_d;
    logic              busy_q,     busy_d;
    logic              timeout_q,  timeout_d;
    logic [HCNT_W-1:0] hold_cnt_q, hold_cnt_d;

    logic              owner_gone;
    logic              hold_expired;
    logic              any_req;
    logic [2:0]        arb_winner;

    // First asserted request at or after the fairness pointer, wrapping mod 8.
    function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] idx;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            idx = p + 3'(k);
            if (!found && r[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        any_req      = |req;
        arb_winner   = rr_pick(req, ptr_q);
        owner_gone   = done | ~req[gnt_idx_q];
        hold_expired = (hold_cnt_q == HOLD_LAST);

        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_idx_d  = gnt_idx_q;
        gnt_en_d   = gnt_en_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = arb_winner;
                    gnt_en_d   = 1'b1;
                    hold_cnt_d = '0;
                end
            end
            ST_GRANT: begin
                // An owner leaving voluntarily masks a coincident hold expiry.
                if (owner_gone || hold_expired) begin
                    state_d    = ST_GAP;
                    gnt_en_d   = 1'b0;
                    ptr_d      = gnt_idx_q + 3'd1;
                    timeout_d  = ~owner_gone;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (any_req) begin
                    state_d    = ST_GRANT;
                    gnt_idx_d  = arb_winner;
                    gnt_en_d   = 1'b1;
                    hold_cnt_d = '0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_en_d   = 1'b0;
                hold_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 3'd0;
            gnt_idx_q  <= 3'd0;
            gnt_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            gnt_en_q   <= gnt_en_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_en  = gnt_en_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;
    // Decoder output: zero whenever the enable is low, regardless of the held index.
    assign gnt     = gnt_en_q ? (8'd1 << gnt_idx_q) : 8'd0;

endmodule
